// File: rtl/sobel_output_checker.sv
// ---------------------------------------------------------------------------
// sobel_output_checker
//
// Compares a filtered output image against a golden image after the filter
// signals completion. Both RAMs share one read address and one read strobe.
// Border pixels must be 0 regardless of the golden contents. Interior pixels
// must equal the golden pixel. The block counts mismatches and remembers the
// address of the first one.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous reset, active low
//   start          : one-cycle pulse starting a pass (ignored while busy)
//   mem_address    : shared read address to output RAM and golden RAM
//   mem_read       : read strobe for both RAMs
//   out_readdata   : filter output pixel, valid 1 cycle after its mem_read
//   gold_readdata  : golden pixel, valid 1 cycle after its mem_read
//   busy           : pass in progress (READ or DRAIN)
//   done           : pass complete; held until the next accepted start
//   errors         : saturating mismatch count of the current/last pass
//   first_err_addr : address of the first mismatch, all-ones if none
//
// Timing: mem_read/mem_address are registered. A start sampled at edge 0
// issues reads at edges 1..N. The compare for address a happens at edge a+3.
// The last compare therefore lands on the DRAIN->DONE edge, N+2.
// ---------------------------------------------------------------------------
module sobel_output_checker #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [DATA_W-1:0] out_readdata,
  input  logic [DATA_W-1:0] gold_readdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       errors,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Read-side counters
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic [ROW_W-1:0]  row_cnt_reg;
  logic [COL_W-1:0]  col_cnt_reg;
  logic              issued_all_reg;   // read of address N-1 has been issued

  // Registered read outputs
  logic              mem_read_reg;
  logic [ADDR_W-1:0] mem_address_reg;

  // Compare pipeline: stage 1 travels with the read strobe, and stage 2
  // lines up with the returning data.
  logic              s1_valid_reg, s2_valid_reg;
  logic [ADDR_W-1:0] s1_addr_reg,  s2_addr_reg;
  logic              s1_rowb_reg,  s2_rowb_reg;
  logic              s1_colb_reg,  s2_colb_reg;

  // Result registers
  logic [31:0]       errors_reg;
  logic [ADDR_W-1:0] first_err_reg;

  logic              accept;
  logic              issue;
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        busy = 1'b1;
        // READ holds one cycle past the last issue. This leaves the final read
        // strobe high for a full cycle before DRAIN.
        if (issued_all_reg) begin
          state_next = DRAIN;
        end else begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Compare
  // -------------------------------------------------------------------------
  always_comb begin
    expected = (s2_rowb_reg || s2_colb_reg) ? '0 : gold_readdata;
    mismatch = s2_valid_reg && (out_readdata != expected);
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt_reg    <= '0;
      row_cnt_reg     <= '0;
      col_cnt_reg     <= '0;
      issued_all_reg  <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_address_reg <= '0;
      s1_valid_reg    <= 1'b0;
      s1_addr_reg     <= '0;
      s1_rowb_reg     <= 1'b0;
      s1_colb_reg     <= 1'b0;
      s2_valid_reg    <= 1'b0;
      s2_addr_reg     <= '0;
      s2_rowb_reg     <= 1'b0;
      s2_colb_reg     <= 1'b0;
      errors_reg      <= '0;
      first_err_reg   <= '1;
    end else begin
      mem_read_reg <= 1'b0;
      s1_valid_reg <= 1'b0;

      if (accept) begin
        addr_cnt_reg   <= '0;
        row_cnt_reg    <= '0;
        col_cnt_reg    <= '0;
        issued_all_reg <= 1'b0;
        errors_reg     <= '0;
        first_err_reg  <= '1;
      end else if (issue) begin
        mem_read_reg    <= 1'b1;
        mem_address_reg <= addr_cnt_reg;
        s1_valid_reg    <= 1'b1;
        s1_addr_reg     <= addr_cnt_reg;
        s1_rowb_reg     <= (row_cnt_reg == '0) || (row_cnt_reg == LAST_ROW);
        s1_colb_reg     <= (col_cnt_reg == '0) || (col_cnt_reg == LAST_COL);
        if (addr_cnt_reg == LAST_ADDR) begin
          // The counter stops at N-1. It does not wrap within a pass.
          issued_all_reg <= 1'b1;
        end else begin
          addr_cnt_reg <= addr_cnt_reg + 1'b1;
          if (col_cnt_reg == LAST_COL) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= row_cnt_reg + 1'b1;
          end else begin
            col_cnt_reg <= col_cnt_reg + 1'b1;
          end
        end
      end

      s2_valid_reg <= s1_valid_reg;
      s2_addr_reg  <= s1_addr_reg;
      s2_rowb_reg  <= s1_rowb_reg;
      s2_colb_reg  <= s1_colb_reg;

      // The pipeline is empty whenever a start can be accepted. A mismatch
      // and a clear therefore never collide.
      if (mismatch && !accept) begin
        if (errors_reg != 32'hFFFF_FFFF) begin
          errors_reg <= errors_reg + 32'd1;
        end
        if (errors_reg == '0) begin
          first_err_reg <= s2_addr_reg;
        end
      end
    end
  end

  assign mem_read       = mem_read_reg;
  assign mem_address    = mem_address_reg;
  assign errors         = errors_reg;
  assign first_err_addr = first_err_reg;

endmodule

// File: tb/tb_sobel_output_checker.sv
// ---------------------------------------------------------------------------
// tb_sobel_output_checker
//
// Directed bench for a 4x4 image. The border addresses are 0-3, 4, 7, 8,
// 11 and 12-15. The interior addresses are 5, 6, 9 and 10.
//
// The baseline golden image is 0 on the border and 8'h10+addr in the
// interior. The baseline output image equals the golden image. Each vector
// patches up to two addresses in both images, then runs a full pass.
// ---------------------------------------------------------------------------
module tb_sobel_output_checker;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int DW     = 8;
  localparam int AW     = 6;
  localparam int NPIX   = W * H;
  localparam logic [AW-1:0] NONE = 6'h3F;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic [DW-1:0] out_readdata;
  logic [DW-1:0] gold_readdata;
  logic          busy;
  logic          done;
  logic [31:0]   errors;
  logic [AW-1:0] first_err_addr;

  logic [DW-1:0] out_mem  [NPIX];
  logic [DW-1:0] gold_mem [NPIX];

  int total = 0;
  int bad   = 0;

  sobel_output_checker #(
    .WIDTH (W),
    .HEIGHT(H),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mem_address   (mem_address),
    .mem_read      (mem_read),
    .out_readdata  (out_readdata),
    .gold_readdata (gold_readdata),
    .busy          (busy),
    .done          (done),
    .errors        (errors),
    .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both RAMs return data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_read) begin
      out_readdata  <= out_mem[mem_address[3:0]];
      gold_readdata <= gold_mem[mem_address[3:0]];
    end
  end

  typedef struct {
    string         name;
    int            pa0;
    logic [DW-1:0] po0;
    logic [DW-1:0] pg0;
    int            pa1;
    logic [DW-1:0] po1;
    logic [DW-1:0] pg1;
    logic [31:0]   exp_err;
    logic [AW-1:0] exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_images(input vec_t v);
    for (int i = 0; i < NPIX; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) gold_mem[i] = 8'h00;
      else gold_mem[i] = 8'h10 + 8'(i);
      out_mem[i] = gold_mem[i];
    end
    if (v.pa0 >= 0) begin
      out_mem[v.pa0]  = v.po0;
      gold_mem[v.pa0] = v.pg0;
    end
    if (v.pa1 >= 0) begin
      out_mem[v.pa1]  = v.po1;
      gold_mem[v.pa1] = v.pg1;
    end
  endtask

  // Pulse start (sampled at edge 0), then watch edges 1..40. If extra > 0, a
  // second start is presented so that it is sampled at edge 'extra'.
  task automatic run_pass(input string nm, input int extra,
                          input logic [31:0] exp_err, input logic [AW-1:0] exp_first);
    int            nreads, addr_bad, done_cyc;
    logic [31:0]   err_at_done;
    logic [AW-1:0] first_at_done;
    nreads        = 0;
    addr_bad      = 0;
    done_cyc      = -1;
    err_at_done   = '0;
    first_at_done = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, " busy after start"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      if (extra > 0 && k == extra) start = 1'b1;
      @(posedge clk);
      #1;
      if (extra > 0 && k == extra) start = 1'b0;
      if (mem_read) begin
        if (mem_address != AW'(nreads)) addr_bad++;
        nreads++;
      end
      if (done) begin
        done_cyc      = k;
        err_at_done   = errors;
        first_at_done = first_err_addr;
      end
    end
    $display("pass %s: reads=%0d done_cycle=%0d errors=%0d first=%0h",
             nm, nreads, done_cyc, err_at_done, first_at_done);
    chk({nm, " read count"}, 64'(nreads), 64'(NPIX));
    chk({nm, " address order bad"}, 64'(addr_bad), 64'd0);
    chk({nm, " done cycle"}, 64'(done_cyc), 64'd18);
    chk({nm, " errors"}, 64'(err_at_done), 64'(exp_err));
    chk({nm, " first_err_addr"}, 64'(first_at_done), 64'(exp_first));
  endtask

  initial begin
    vec_t none_v;
    vecs[0] = '{"clean",          -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, 32'd0, NONE};
    vecs[1] = '{"interior 5,10",   5, 8'hAA, 8'h15, 10, 8'hBB, 8'h1A, 32'd2, 6'd5};
    vecs[2] = '{"border3 nonzero", 3, 8'h01, 8'h01, -1, 8'h00, 8'h00, 32'd1, 6'd3};
    vecs[3] = '{"gold border",     0, 8'h00, 8'h7F, -1, 8'h00, 8'h00, 32'd0, NONE};
    vecs[4] = '{"last pixel",     15, 8'h01, 8'h00, -1, 8'h00, 8'h00, 32'd1, 6'd15};
    vecs[5] = '{"addr 9 and 12",   9, 8'h00, 8'h19, 12, 8'h05, 8'h00, 32'd2, 6'd9};
    none_v  = vecs[0];

    reset         = 1'b0;
    start         = 1'b0;
    out_readdata  = '0;
    gold_readdata = '0;
    load_images(none_v);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset mem_read", 64'(mem_read), 64'd0);
    chk("reset mem_address", 64'(mem_address), 64'd0);
    chk("reset errors", 64'(errors), 64'd0);
    chk("reset first_err_addr", 64'(first_err_addr), 64'(NONE));
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle after reset busy", 64'(busy), 64'd0);

    // Back-to-back passes. Each start after done also checks that the
    // previous result was cleared.
    for (int i = 0; i < 6; i++) begin
      load_images(vecs[i]);
      run_pass(vecs[i].name, 0, vecs[i].exp_err, vecs[i].exp_first);
    end

    // A start sampled at edge 6 is ignored while busy.
    load_images(vecs[1]);
    run_pass("start while busy", 6, 32'd2, 6'd5);

    // Assert reset mid-pass between clock edges.
    load_images(vecs[1]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre-abort errors", 64'(errors), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    $display("abort: busy=%0d mem_read=%0d errors=%0d done=%0d", busy, mem_read, errors, done);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort mem_read", 64'(mem_read), 64'd0);
    chk("abort errors", 64'(errors), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort first_err_addr", 64'(first_err_addr), 64'(NONE));
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("post-abort no done", 64'(done), 64'd0);
    chk("post-abort idle busy", 64'(busy), 64'd0);

    load_images(none_v);
    run_pass("after abort", 0, 32'd0, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
